// File: rtl/vga_timing_gen_if.sv
// Video timing bus produced by vga_timing_gen: frame-store address counters,
// delayed sync/visible qualifiers, frame pulse and test-pattern pixel.
interface vga_timing_gen_if;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        fetch_valid;
  logic        visible;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [7:0]  pattern_color;

  modport master (
    output hc, vc, fetch_valid, visible, hsync, vsync, frame_start, pattern_color
  );

  modport slave (
    input hc, vc, fetch_valid, visible, hsync, vsync, frame_start, pattern_color
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: h/v counters, sync decode and a ce-gated delay line
// aligning visible/hsync/vsync with memory data. Optional ramp: VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 1..4");
  end

  logic [10:0] hc;
  logic [9:0]  vc;
  logic        h_wrap;
  logic        v_wrap;
  logic        fetch_valid;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        frame_start;

  logic [SYNC_DELAY-1:0] vis_sr;
  logic [SYNC_DELAY-1:0] hs_sr;
  logic [SYNC_DELAY-1:0] vs_sr;

  always_comb begin
    h_wrap      = (hc == H_LAST);
    v_wrap      = (vc == V_LAST);
    fetch_valid = (hc < H_ACT) && (vc < V_ACT);
    hsync_raw   = !((hc >= HS_START) && (hc < HS_END));
    vsync_raw   = !((vc >= VS_START) && (vc < VS_END));
  end

  // frame_start is registered from the wrap condition, so it is high for the
  // single clock following the (H_TOTAL-1, V_TOTAL-1) -> (0, 0) edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce && h_wrap && v_wrap;
      if (ce) begin
        hc <= h_wrap ? '0 : hc + 11'd1;
        if (h_wrap) begin
          vc <= v_wrap ? '0 : vc + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vis_sr <= '0;
      hs_sr  <= '1;
      vs_sr  <= '1;
    end else if (ce) begin
      vis_sr[0] <= fetch_valid;
      hs_sr[0]  <= hsync_raw;
      vs_sr[0]  <= vsync_raw;
      for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
        vis_sr[i] <= vis_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] pat_sr [SYNC_DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_DELAY; i++) begin
        pat_sr[i] <= '0;
      end
    end else if (ce) begin
      pat_sr[0] <= hc[9:2];
      for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
        pat_sr[i] <= pat_sr[i-1];
      end
    end
  end

  // Gating on the delayed visible keeps the ramp black through blanking.
  assign vid.pattern_color = vis_sr[SYNC_DELAY-1] ? pat_sr[SYNC_DELAY-1] : '0;
`else
  assign vid.pattern_color = '0;
`endif

  assign vid.hc          = hc;
  assign vid.vc          = vc;
  assign vid.fetch_valid = fetch_valid;
  assign vid.visible     = vis_sr[SYNC_DELAY-1];
  assign vid.hsync       = hs_sr[SYNC_DELAY-1];
  assign vid.vsync       = vs_sr[SYNC_DELAY-1];
  assign vid.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 56x11 frame with SYNC_DELAY=3.
module tb_vga_timing_gen;
  localparam int HV = 40, HF = 4, HS = 6, HB = 6;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int D  = 3;
  localparam int HT = HV + HF + HS + HB;  // 56
  localparam int VT = VV + VF + VS + VB;  // 11
  localparam int FT = HT * VT;            // 616

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_DELAY(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .vid(vif.master)
  );

  always #5 clk = ~clk;

  int  ncheck = 0;
  int  nbad   = 0;
  int  t      = 0;   // pixel ticks since reset release
  bit  fs_exp = 1'b0;

  logic [33:0] act;
  assign act = {vif.hc, vif.vc, vif.fetch_valid, vif.visible, vif.hsync,
                vif.vsync, vif.frame_start, vif.pattern_color};

  function automatic bit m_fv(int tt);
    return ((tt % HT) < HV) && (((tt / HT) % VT) < VV);
  endfunction

  function automatic logic [33:0] exp_vec(int tt, bit fs);
    int hcv, vcv, hd, vd;
    logic [10:0] h11;
    logic [9:0]  v10;
    logic vis, hsn, vsn;
    logic [7:0] pat;
    hcv = tt % HT;
    vcv = (tt / HT) % VT;
    h11 = 11'(hcv);
    v10 = 10'(vcv);
    vis = 1'b0; hsn = 1'b1; vsn = 1'b1; pat = 8'd0;
    if (tt >= D) begin
      hd  = (tt - D) % HT;
      vd  = ((tt - D) / HT) % VT;
      vis = m_fv(tt - D);
      hsn = !(hd >= HV + HF && hd < HV + HF + HS);
      vsn = !(vd >= VV + VF && vd < VV + VF + VS);
`ifdef VGA_TEST_PATTERN_EN
      if (vis) pat = 8'(hd / 4);
`endif
    end
    return {h11, v10, m_fv(tt), vis, hsn, vsn, fs, pat};
  endfunction

  task automatic step(input bit c);
    ce = c;
    @(negedge clk);
    if (c) t++;
    fs_exp = c && (t > 0) && (t % FT == 0);
  endtask

  task automatic pulse_reset();
    ce = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    fs_exp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    repeat (3) @(negedge clk);
    ncheck++;
    if (act !== exp_vec(0, 1'b0)) begin
      nbad++;
      $display("FAIL reset_state got=%h exp=%h", act, exp_vec(0, 1'b0));
    end
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_horizontal();
    int hs_low = 0, fv_high = 0;
    for (int k = 0; k < 2 * HT; k++) begin
      step(1'b1);
      if (!vif.hsync) hs_low++;
      if (vif.fetch_valid) fv_high++;
      ncheck++;
      if (act !== exp_vec(t, fs_exp)) begin
        nbad++;
        $display("FAIL horiz t=%0d got=%h exp=%h", t, act, exp_vec(t, fs_exp));
      end
      if (t == HT) begin
        ncheck++;
        if (vif.hc !== 11'd0 || vif.vc !== 10'd1) begin
          nbad++;
          $display("FAIL hwrap hc=%0d vc=%0d exp 0/1", vif.hc, vif.vc);
        end
      end
    end
    ncheck++;
    if (hs_low != 12) begin
      nbad++;
      $display("FAIL hsync_low_ticks got=%0d exp=12", hs_low);
    end
    ncheck++;
    if (fv_high != 80) begin
      nbad++;
      $display("FAIL fetch_valid_ticks got=%0d exp=80", fv_high);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vs_low = 0;
    while (t < 2 * FT + 4) begin
      step(1'b1);
      if (vif.frame_start) fs_cnt++;
      if (!vif.vsync) vs_low++;
      ncheck++;
      if (act !== exp_vec(t, fs_exp)) begin
        nbad++;
        $display("FAIL frame t=%0d got=%h exp=%h", t, act, exp_vec(t, fs_exp));
      end
    end
    ncheck++;
    if (fs_cnt != 2) begin
      nbad++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
    end
    ncheck++;
    if (vs_low != 4 * HT) begin
      nbad++;
      $display("FAIL vsync_low_ticks got=%0d exp=%0d", vs_low, 4 * HT);
    end
  endtask

  task automatic test_ce();
    int fs_clocks = 0;
    for (int k = 0; k < 4 * (FT + 8); k++) begin
      step(k % 4 == 0);
      if (vif.frame_start) fs_clocks++;
      ncheck++;
      if (act !== exp_vec(t, fs_exp)) begin
        nbad++;
        $display("FAIL ce_quarter k=%0d t=%0d got=%h exp=%h", k, t, act, exp_vec(t, fs_exp));
      end
    end
    ncheck++;
    if (fs_clocks != 1) begin
      nbad++;
      $display("FAIL frame_start_width got=%0d exp=1", fs_clocks);
    end
  endtask

  task automatic test_reset_midframe();
    repeat (100) step(1'b1);
    ce = 1'b1;
    #2 rst = 1'b1;
    #1;
    ncheck++;
    if (act !== exp_vec(0, 1'b0)) begin
      nbad++;
      $display("FAIL async_reset got=%h exp=%h", act, exp_vec(0, 1'b0));
    end
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      ncheck++;
      if (vif.hc !== 11'(k) || act !== exp_vec(t, fs_exp)) begin
        nbad++;
        $display("FAIL post_reset_count hc=%0d exp=%0d", vif.hc, k);
      end
    end
  endtask

  task automatic test_delay();
    int rise = -1;
    pulse_reset();
    ncheck++;
    if (vif.fetch_valid !== 1'b1 || vif.visible !== 1'b0) begin
      nbad++;
      $display("FAIL delay_start fv=%b vis=%b exp 1/0", vif.fetch_valid, vif.visible);
    end
    for (int k = 0; k < 10 && rise < 0; k++) begin
      step(1'b1);
      if (vif.visible === 1'b1) rise = t;
    end
    ncheck++;
    if (rise != D) begin
      nbad++;
      $display("FAIL visible_rise_tick got=%0d exp=%0d", rise, D);
    end
  endtask

  task automatic test_pattern();
    int at_t [3] = '{23, 42, 48};
    logic [7:0] want [3];
`ifdef VGA_TEST_PATTERN_EN
    want = '{8'd5, 8'd9, 8'd0};
`else
    want = '{8'd0, 8'd0, 8'd0};
`endif
    pulse_reset();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 60 && t < at_t[n]; k++) step(1'b1);
      ncheck++;
      if (vif.pattern_color !== want[n] || act !== exp_vec(t, fs_exp)) begin
        nbad++;
        $display("FAIL pattern t=%0d got=%0d exp=%0d", t, vif.pattern_color, want[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_frame();
    test_ce();
    test_reset_midframe();
    test_delay();
    test_pattern();
    $display("test done: total=%0d bad=%0d", ncheck, nbad);
    $finish;
  end
endmodule
